// File: rtl/sha512_pkg.sv
// Shared constants and types for the masked SHA-512 message-schedule controller.
//   WORD       : word width in bits
//   SCHED_LEN  : number of schedule words W_0..W_79
//   BUF_DEPTH  : depth of the circular word buffer
//   S0_*/S1_*  : rotate/shift amounts of the small sigma functions
//   state_e    : controller state encoding
package sha512_pkg;

  localparam int unsigned WORD      = 64;
  localparam int unsigned SCHED_LEN = 80;
  localparam int unsigned BUF_DEPTH = 16;

  localparam int unsigned S0_R1  = 1;
  localparam int unsigned S0_R2  = 8;
  localparam int unsigned S0_SHR = 7;
  localparam int unsigned S1_R1  = 19;
  localparam int unsigned S1_R2  = 61;
  localparam int unsigned S1_SHR = 6;

  typedef enum logic [2:0] {
    StLoad,
    StEmit,
    StIss1,
    StIss2,
    StWait12,
    StIss3,
    StWait3,
    StOut
  } state_e;

endpackage

// File: rtl/masked_sha512_schedule_ctrl_if.sv
// Handshake bundle of the masked SHA-512 schedule controller.
//   in_*      : shared message words from the block loader
//   out_*     : shared schedule words W_t to the compression core
//   add_*     : issue/return channel of the external masked adder gadget
// Modport slave is the controller's view, master the surrounding environment.
interface masked_sha512_schedule_ctrl_if #(
  parameter int unsigned D = 2
);
  localparam int unsigned W = D * sha512_pkg::WORD;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         add_valid;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_res_valid;
  logic [W-1:0] add_res;

  modport slave (
    input  in_valid, in_data, out_ready, add_res_valid, add_res,
    output in_ready, out_valid, out_data, out_last, add_valid, add_a, add_b
  );

  modport master (
    output in_valid, in_data, out_ready, add_res_valid, add_res,
    input  in_ready, out_valid, out_data, out_last, add_valid, add_a, add_b
  );

endinterface

// File: rtl/sha_small_sigma_gadget.sv
// Share-wise small sigma: ROTR(R1) ^ ROTR(R2) ^ SHR(Shr) on a bit-major shared word.
//   x_i : shared input word, bit i in [i*D +: D]
//   y_o : shared result, same layout
// Every bit moves as a whole D-bit group, so the shares are never mixed together.
module sha_small_sigma_gadget import sha512_pkg::*; #(
  parameter int unsigned D   = 2,
  parameter int unsigned R1  = 1,
  parameter int unsigned R2  = 8,
  parameter int unsigned Shr = 7
) (
  input  logic [D*WORD-1:0] x_i,
  output logic [D*WORD-1:0] y_o
);

  for (genvar i = 0; i < WORD; i++) begin : g_bit
    localparam int unsigned RotA = (i + R1) % WORD;
    localparam int unsigned RotB = (i + R2) % WORD;
    if (i + Shr < WORD) begin : g_shr
      assign y_o[i*D +: D] = x_i[RotA*D +: D] ^ x_i[RotB*D +: D] ^ x_i[(i+Shr)*D +: D];
    end else begin : g_fill
      // Shifted-in positions are zero groups in every share.
      assign y_o[i*D +: D] = x_i[RotA*D +: D] ^ x_i[RotB*D +: D];
    end
  end

endmodule

// File: rtl/masked_sha512_schedule_ctrl.sv
// Masked SHA-512 message schedule controller.
//   clk   : clock
//   rst   : synchronous active-high reset
//   sched : handshake bundle (loader in, W_t out, external masked adder)
// Loads 16 shared words, emits them, then derives W_16..W_79 in a 16-entry
// circular buffer. Sigmas are applied share-wise; all additions go to the adder.
module masked_sha512_schedule_ctrl import sha512_pkg::*; #(
  parameter int unsigned D = 2
) (
  input logic                          clk,
  input logic                          rst,
  masked_sha512_schedule_ctrl_if.slave sched
);

  localparam int unsigned W         = D * WORD;
  localparam logic [6:0]  TLast     = 7'(SCHED_LEN - 1);
  localparam logic [6:0]  TEmitLast = 7'(BUF_DEPTH - 1);

  state_e       state_q;
  logic [6:0]   t_q;
  logic [3:0]   idx;
  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] s1_q, s2_q;
  logic         first_seen_q;
  logic         in_ready_q, out_valid_q, out_last_q, add_valid_q;
  logic [W-1:0] out_data_q, add_a_q, add_b_q;
  logic [W-1:0] sig0_x, sig0_y, sig1_x, sig1_y;

  assign idx    = t_q[3:0];
  assign sig1_x = mem_q[idx - 4'd2];
  assign sig0_x = mem_q[idx - 4'd15];

  sha_small_sigma_gadget #(
    .D  (D),
    .R1 (S0_R1),
    .R2 (S0_R2),
    .Shr(S0_SHR)
  ) u_sigma0 (
    .x_i(sig0_x),
    .y_o(sig0_y)
  );

  sha_small_sigma_gadget #(
    .D  (D),
    .R1 (S1_R1),
    .R2 (S1_R2),
    .Shr(S1_SHR)
  ) u_sigma1 (
    .x_i(sig1_x),
    .y_o(sig1_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      t_q          <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      add_valid_q  <= 1'b0;
      first_seen_q <= 1'b0;
      out_data_q   <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
    end else begin
      add_valid_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (sched.in_valid) begin
            mem_q[idx] <= sched.in_data;
            if (t_q == TEmitLast) begin
              in_ready_q <= 1'b0;
              t_q        <= '0;
              state_q    <= StEmit;
            end else begin
              t_q <= t_q + 7'd1;
            end
          end
        end
        StEmit, StOut: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[idx];
            out_last_q  <= (t_q == TLast);
          end else if (sched.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (t_q == TLast) begin
              t_q        <= '0;
              in_ready_q <= 1'b1;
              state_q    <= StLoad;
            end else begin
              t_q <= t_q + 7'd1;
              if (state_q == StOut || t_q == TEmitLast) state_q <= StIss1;
            end
          end
        end
        StIss1: begin
          add_valid_q <= 1'b1;
          add_a_q     <= sig1_y;
          add_b_q     <= mem_q[idx - 4'd7];
          state_q     <= StIss2;
        end
        StIss2: begin
          // W_{t-16} lives in the slot that W_t will overwrite.
          add_valid_q  <= 1'b1;
          add_a_q      <= sig0_y;
          add_b_q      <= mem_q[idx];
          first_seen_q <= 1'b0;
          state_q      <= StWait12;
        end
        StWait12: begin
          if (sched.add_res_valid) begin
            if (!first_seen_q) begin
              s1_q         <= sched.add_res;
              first_seen_q <= 1'b1;
            end else begin
              s2_q         <= sched.add_res;
              first_seen_q <= 1'b0;
              state_q      <= StIss3;
            end
          end
        end
        StIss3: begin
          add_valid_q <= 1'b1;
          add_a_q     <= s1_q;
          add_b_q     <= s2_q;
          state_q     <= StWait3;
        end
        StWait3: begin
          if (sched.add_res_valid) begin
            mem_q[idx] <= sched.add_res;
            state_q    <= StOut;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign sched.in_ready  = in_ready_q;
  assign sched.out_valid = out_valid_q;
  assign sched.out_data  = out_data_q;
  assign sched.out_last  = out_last_q;
  assign sched.add_valid = add_valid_q;
  assign sched.add_a     = add_a_q;
  assign sched.add_b     = add_b_q;

endmodule

// File: doc/masked_sha512_schedule_ctrl.md
Name: masked_sha512_schedule_ctrl

Overview:
- Sequences generation of the masked SHA-512 message schedule W_0..W_79 from one 16-word block.
- Holds a 16-entry circular buffer of Boolean-shared 64-bit words.
- Applies the share-wise linear small sigmas internally and schedules every nonlinear addition onto one external masked 64-bit adder gadget.
- Sits between the block loader and the masked compression-round core.

Parameters:
- d, 2, number of Boolean shares per bit.
- WORD, 64, word width (fixed for SHA-512; not meant to be overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  load word valid.
- in_ready  output  1  load word accepted when in_valid && in_ready.
- in_data  input  d*WORD  shared message word.
- out_valid  output  1  W_t available.
- out_ready  input  1  consumer accepts W_t.
- out_data  output  d*WORD  shared W_t.
- out_last  output  1  high with t=79.
- add_valid  output  1  one-cycle issue pulse to the adder.
- add_a  output  d*WORD  adder operand A.
- add_b  output  d*WORD  adder operand B.
- add_res_valid  input  1  adder result valid; results return in issue order.
- add_res  input  d*WORD  shared sum.

Behaviour:
- Share layout is bit-major: bit i occupies [i*d +: d].
- Rotations permute d-bit groups. SHR fills zero groups in every share.
- sigma0 = ROTR1 ^ ROTR8 ^ SHR7. sigma1 = ROTR19 ^ ROTR61 ^ SHR6. Both are computed share-wise and combinationally, with no randomness.
- Reset (sync): state=LOAD, t=0, in_ready=1, out_valid=0, out_last=0, add_valid=0. Buffer contents are don't-care.
- LOAD:
  - Each accepted word is written to buf[t[3:0]] and t increments.
  - After the 16th accept: in_ready=0, t=0, go to EMIT.
- EMIT with t<16: out_data=buf[t], out_valid=1. On handshake t++. Output becomes valid the cycle after entering the state or after the previous handshake.
- For t>=16, with indices mod 16:
  - ISS1: add_a=sigma1(buf[t-2]), add_b=buf[t-7], add_valid=1 for one cycle.
  - ISS2 (next cycle): add_a=sigma0(buf[t-15]), add_b=buf[t-16].
  - WAIT12: capture first result as s1 and second as s2.
  - ISS3: add_a=s1, add_b=s2.
  - WAIT3: on the result, write buf[t[3:0]]=result. This overwrites W_{t-16}, already issued. Go to OUT.
  - OUT: out_data=buf[t[3:0]], out_valid=1. On handshake t++. If t was 79, go to LOAD.
- Minimum per-word latency for t>=16 is 2*ADD_LATENCY+3 cycles. The block tolerates any adder latency >=1.
- out_last=1 exactly while presenting t=79.
- out_valid and out_data stay stable until accepted while out_ready=0.
- add_res_valid outside WAIT12/WAIT3 is ignored.
- in_valid outside LOAD is ignored (in_ready=0).
- rst mid-operation aborts immediately to the reset state. Partial schedule is discarded, and the next block must be reloaded from word 0.
- No unmasked value is formed. Shares of a word are never combined in the datapath.

Decomposition:
- Shared package sha512_pkg: WORD, schedule length 80, buffer depth 16, rotation/shift constants (1,8,7,19,61,6), state enum.
- One natural sub-module: sha_small_sigma_gadget. It is parameterised by d and three constants (r1, r2, shr) and instantiated twice (sigma0 and sigma1).
- Adder gadget stays external.

Test Plan:
- "abc" block (W0=0x6162638000000000, W1..W14=0, W15=0x18), random shares, adder model latency 3 -> recombined outputs W0..W15 echo input, W16=0x6162638000000000, W17=0x00030000000000C0. W18..W79 match a software model; out_last only on t=79.
- Same block with adder latency 1 and latency 7 -> identical recombined W stream; issue order on add_a/add_b is ISS1, ISS2, ISS3 per word.
- out_ready held low 10 cycles at t=20 -> out_data constant, no extra add_valid pulses, and t=21 follows correctly.
- rst asserted during WAIT12 of t=40 -> next cycle in_ready=1, out_valid=0. A fresh "abc" load reproduces W0..W79 exactly.
- Back-to-back blocks: second load accepted after t=79 handshake -> second schedule correct; in_ready=0 throughout EMIT.
- Share-independence check: the same message under two different random sharings -> recombined outputs identical, and the per-share outputs differ.
